// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the single-master bus interconnect:
//               FSM state encoding, HB transfer-size codes and the default
//               slave address map (up to 8 slots, 256 MB windows).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int BUS_ADDR_W = 32;

  // Interconnect FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // HB transfer-size codes carried with each transaction
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  // Default map for the largest legal slave count; the top slices off the
  // low NSLV words. Slot i owns 0xi000_0000..0xiFFF_FFFF.
  localparam logic [8*BUS_ADDR_W-1:0] BUS_DEF_BASE = {
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [8*BUS_ADDR_W-1:0] BUS_DEF_MASK = {8{32'hF000_0000}};

endpackage
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_addr_decode
// Description : Combinational address decoder. Each slot matches when
//               (addr & mask) == (base & mask); the lowest matching index
//               wins so the hit vector is always one-hot or zero.
// Ports       : addr_i  - address to decode
//               hit_o   - one-hot winning slot (zero on a miss)
//               miss_o  - no slot matched
// Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int                        NSLV     = 4,
  parameter logic [NSLV*BUS_ADDR_W-1:0] SLV_BASE = BUS_DEF_BASE[NSLV*BUS_ADDR_W-1:0],
  parameter logic [NSLV*BUS_ADDR_W-1:0] SLV_MASK = BUS_DEF_MASK[NSLV*BUS_ADDR_W-1:0]
) (
  input  logic [BUS_ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]       hit_o,
  output logic                  miss_o
);

  logic [NSLV-1:0] match;

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_match
    assign match[gi] = ((addr_i & SLV_MASK[gi*BUS_ADDR_W +: BUS_ADDR_W]) ==
                        (SLV_BASE[gi*BUS_ADDR_W +: BUS_ADDR_W] &
                         SLV_MASK[gi*BUS_ADDR_W +: BUS_ADDR_W]));
  end

  // Overlapping windows resolve to the lowest index.
  always_comb begin
    logic found;
    hit_o = '0;
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (match[i] && !found) begin
        hit_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign miss_o = ~(|match);

endmodule
`default_nettype wire

// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : bus_interconnect
// Description : Single-master to NSLV-slave bus interconnect. A request is
//               latched in IDLE and decoded; hits are forwarded to one slave
//               (ACTIVE) until that slave grants or a timeout expires, then a
//               one-cycle completion pulse is returned to the master (RESP).
// Ports       : i_CLK, i_RSTn               - clock, async active-low reset
//               i_M_REQ/WE/RE/ADDR/WDATA/HB - master request
//               o_M_GNT/RDATA/ERR           - master completion
//               o_S_CE/REQ/WE/ADDR/WDATA/HB - slave-side request
//               i_S_GNT/RDATA               - per-slave grant and read data
//               o_ERR_ADDR                  - address of last failed access
// Revision    : 1.0 - initial release
// ============================================================================
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                        NSLV     = 4,
  parameter int                        DATA_W   = 32,
  parameter logic [NSLV*BUS_ADDR_W-1:0] SLV_BASE = BUS_DEF_BASE[NSLV*BUS_ADDR_W-1:0],
  parameter logic [NSLV*BUS_ADDR_W-1:0] SLV_MASK = BUS_DEF_MASK[NSLV*BUS_ADDR_W-1:0],
  parameter int                        TIMEOUT  = 255
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTn,
  input  logic                     i_M_REQ,
  input  logic                     i_M_WE,
  input  logic                     i_M_RE,
  input  logic [BUS_ADDR_W-1:0]    i_M_ADDR,
  input  logic [DATA_W-1:0]        i_M_WDATA,
  input  logic [1:0]               i_M_HB,
  output logic                     o_M_GNT,
  output logic [DATA_W-1:0]        o_M_RDATA,
  output logic                     o_M_ERR,
  output logic [NSLV-1:0]          o_S_CE,
  output logic                     o_S_REQ,
  output logic                     o_S_WE,
  output logic [BUS_ADDR_W-1:0]    o_S_ADDR,
  output logic [DATA_W-1:0]        o_S_WDATA,
  output logic [1:0]               o_S_HB,
  input  logic [NSLV-1:0]          i_S_GNT,
  input  logic [NSLV*DATA_W-1:0]   i_S_RDATA,
  output logic [BUS_ADDR_W-1:0]    o_ERR_ADDR
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  bus_state_e            state_q;
  logic [NSLV-1:0]       sel_q;
  logic [BUS_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  we_q;
  logic                  re_q;
  logic [1:0]            hb_q;
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;
  logic                  gnt_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [BUS_ADDR_W-1:0] err_addr_q;

  logic [NSLV-1:0]       dec_hit;
  logic                  dec_miss;
  logic                  slv_gnt;
  logic [DATA_W-1:0]     slv_rdata;
  logic                  capture_rd;

  bus_addr_decode #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (i_M_ADDR),
    .hit_o  (dec_hit),
    .miss_o (dec_miss)
  );

  // Only the latched slot's grant and data are observed.
  assign slv_gnt = |(i_S_GNT & sel_q);

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) slv_rdata = slv_rdata | i_S_RDATA[i*DATA_W +: DATA_W];
    end
  end

  // A pure write (WE without RE) keeps the previous read data.
  assign capture_rd = !(we_q && !re_q);
  assign cnt_d      = cnt_q + 16'd1;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      hb_q       <= '0;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      // Completion flags are single-cycle pulses that accompany RESP.
      gnt_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_M_REQ) begin
            addr_q  <= i_M_ADDR;
            wdata_q <= i_M_WDATA;
            we_q    <= i_M_WE;
            re_q    <= i_M_RE;
            hb_q    <= i_M_HB;
            sel_q   <= dec_hit;
            if (dec_miss) begin
              state_q    <= ST_RESP;
              gnt_q      <= 1'b1;
              err_q      <= 1'b1;
              rdata_q    <= '0;
              err_addr_q <= i_M_ADDR;
            end else begin
              state_q <= ST_ACTIVE;
              cnt_q   <= 16'd1;
            end
          end
        end
        ST_ACTIVE: begin
          // Grant is tested first so it wins on the timeout cycle.
          if (slv_gnt) begin
            if (capture_rd) rdata_q <= slv_rdata;
            state_q <= ST_RESP;
            gnt_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q >= TO_LIMIT) begin
            state_q    <= ST_RESP;
            gnt_q      <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= '0;
            err_addr_q <= addr_q;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_M_GNT    = gnt_q;
  assign o_M_ERR    = err_q;
  assign o_M_RDATA  = rdata_q;
  assign o_ERR_ADDR = err_addr_q;
  assign o_S_REQ    = (state_q == ST_ACTIVE);
  assign o_S_CE     = (state_q == ST_ACTIVE) ? sel_q : '0;
  assign o_S_WE     = we_q;
  assign o_S_ADDR   = addr_q;
  assign o_S_WDATA  = wdata_q;
  assign o_S_HB     = hb_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_interconnect
// Description : Self-checking bench for bus_interconnect. A transaction-level
//               model predicts, for each cycle of a transaction, what the
//               master and slave sides must show; directed cases pin the
//               model with literal values, then randomized traffic follows.
//               A second instance with two identical windows checks priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_req, m_we, m_re;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_hb;
  logic        m_gnt, m_err;
  logic [31:0] m_rdata;
  logic [3:0]  s_ce;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_hb;
  logic [3:0]  s_gnt;
  logic [127:0] s_rdata;
  logic [31:0] err_addr;

  bus_interconnect #(.NSLV(4), .DATA_W(32), .TIMEOUT(TO)) u_dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_M_REQ(m_req), .i_M_WE(m_we), .i_M_RE(m_re),
    .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata), .i_M_HB(m_hb),
    .o_M_GNT(m_gnt), .o_M_RDATA(m_rdata), .o_M_ERR(m_err),
    .o_S_CE(s_ce), .o_S_REQ(s_req), .o_S_WE(s_we),
    .o_S_ADDR(s_addr), .o_S_WDATA(s_wdata), .o_S_HB(s_hb),
    .i_S_GNT(s_gnt), .i_S_RDATA(s_rdata), .o_ERR_ADDR(err_addr)
  );

  // Two slots with the same window; both always grant.
  logic        o_gnt, o_err, o_sreq, o_swe;
  logic [31:0] o_rdata, o_saddr, o_swdata, o_eaddr;
  logic [1:0]  o_ce, o_shb;
  logic [1:0]  o_sgnt = 2'b11;
  logic [63:0] o_srdata = {32'hBBBB_1111, 32'hAAAA_0000};

  bus_interconnect #(.NSLV(2), .DATA_W(32), .SLV_BASE(64'h0),
                     .SLV_MASK({2{32'hF000_0000}}), .TIMEOUT(TO)) u_ovl (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_M_REQ(m_req), .i_M_WE(m_we), .i_M_RE(m_re),
    .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata), .i_M_HB(m_hb),
    .o_M_GNT(o_gnt), .o_M_RDATA(o_rdata), .o_M_ERR(o_err),
    .o_S_CE(o_ce), .o_S_REQ(o_sreq), .o_S_WE(o_swe),
    .o_S_ADDR(o_saddr), .o_S_WDATA(o_swdata), .o_S_HB(o_shb),
    .i_S_GNT(o_sgnt), .i_S_RDATA(o_srdata), .o_ERR_ADDR(o_eaddr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle expectations and transaction-level model state
  bit          chk_en;
  logic        exp_gnt, exp_err, exp_sreq;
  logic [3:0]  exp_ce;
  logic [31:0] mdl_rdata, mdl_eaddr, mdl_addr, mdl_wdata;
  logic        mdl_we;
  logic [1:0]  mdl_hb;

  // Observations gathered by the compare step
  int          cur_k, gnt_cycle, ce_cnt, sreq_cnt;
  logic [3:0]  last_ce;
  logic        last_err;
  logic [1:0]  ovl_ce_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, then move to just after
  // the next rising edge where new stimulus is driven.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      chk("m_gnt",   64'(m_gnt),   64'(exp_gnt));
      chk("m_err",   64'(m_err),   64'(exp_err));
      chk("m_rdata", 64'(m_rdata), 64'(mdl_rdata));
      chk("err_addr",64'(err_addr),64'(mdl_eaddr));
      chk("s_ce",    64'(s_ce),    64'(exp_ce));
      chk("s_req",   64'(s_req),   64'(exp_sreq));
      chk("s_addr",  64'(s_addr),  64'(mdl_addr));
      chk("s_wdata", 64'(s_wdata), 64'(mdl_wdata));
      chk("s_we",    64'(s_we),    64'(mdl_we));
      chk("s_hb",    64'(s_hb),    64'(mdl_hb));
    end
    if (s_ce != 4'b0) begin ce_cnt++; last_ce = s_ce; end
    if (s_req) sreq_cnt++;
    if (m_gnt) begin gnt_cycle = cur_k; last_err = m_err; end
    ovl_ce_acc = ovl_ce_acc | o_ce;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mdl_rdata = '0; mdl_eaddr = '0; mdl_addr = '0;
    mdl_wdata = '0; mdl_we = 1'b0; mdl_hb = '0;
  endtask

  // One master transaction. d = ACTIVE cycle (1-based) in which the target
  // slave grants; d > TO means it never grants in time. gdata is the data
  // the target presents with its grant. Must be called in an IDLE cycle.
  task automatic txn(input logic [31:0] addr, input logic we, input int d,
                     input logic [31:0] gdata, input bit hold, input bit noise_all);
    int  slot;
    bit  miss;
    int  lat;
    bit  err;
    logic [31:0] wd;
    logic [1:0]  hb;
    // Default map: one 256 MB window per slot, slots 0..3
    slot = int'(addr[31:28]);
    miss = (slot >= 4);
    if (miss)         begin lat = 1;     err = 1'b1; end
    else if (d <= TO) begin lat = d + 1; err = 1'b0; end
    else              begin lat = TO + 1; err = 1'b1; end
    wd = $urandom;
    hb = 2'($urandom_range(0, 2));

    // Cycle 0: request presented while idle
    m_req = 1'b1; m_addr = addr; m_we = we; m_re = !we; m_wdata = wd; m_hb = hb;
    for (int j = 0; j < 4; j++) begin
      s_gnt[j] = noise_all ? 1'b1 : 1'($urandom);
      s_rdata[j*32 +: 32] = $urandom;
    end
    cur_k = 0;
    exp_gnt = 1'b0; exp_err = 1'b0; exp_ce = '0; exp_sreq = 1'b0;
    step();
    mdl_addr = addr; mdl_wdata = wd; mdl_we = we; mdl_hb = hb;

    for (int k = 1; k <= lat; k++) begin
      if (!hold) m_req = 1'b0;
      for (int j = 0; j < 4; j++) begin
        s_rdata[j*32 +: 32] = $urandom;
        if (!miss && j == slot) begin
          s_gnt[j] = (k == d);
          if (k == d) s_rdata[j*32 +: 32] = gdata;
        end else begin
          s_gnt[j] = noise_all ? 1'b1 : 1'($urandom);
        end
      end
      cur_k = k;
      if (k < lat) begin
        exp_gnt = 1'b0; exp_err = 1'b0; exp_sreq = 1'b1;
        exp_ce  = 4'(1 << slot);
      end else begin
        exp_gnt = 1'b1; exp_err = err; exp_sreq = 1'b0; exp_ce = '0;
        if (err) begin
          mdl_rdata = '0;
          mdl_eaddr = addr;
        end else if (!we) begin
          mdl_rdata = gdata;
        end
      end
      step();
    end
    // Back in IDLE; whatever follows drives this cycle
    exp_gnt = 1'b0; exp_err = 1'b0; exp_sreq = 1'b0; exp_ce = '0;
    s_gnt = '0;
  endtask

  int ce0, sreq0;

  initial begin
    m_req = 1'b0; m_we = 1'b0; m_re = 1'b0; m_addr = '0; m_wdata = '0; m_hb = '0;
    s_gnt = '0; s_rdata = '0;
    chk_en = 1'b0; cur_k = 0; gnt_cycle = -1; ce_cnt = 0; sreq_cnt = 0;
    last_ce = '0; last_err = 1'b0; ovl_ce_acc = '0;
    exp_gnt = 1'b0; exp_err = 1'b0; exp_ce = '0; exp_sreq = 1'b0;
    model_reset();

    // Reset state, with a request already pending
    m_req = 1'b1; m_addr = 32'h1000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",   64'(m_gnt), 64'h0);
    chk("rst_err",   64'(m_err), 64'h0);
    chk("rst_ce",    64'(s_ce),  64'h0);
    chk("rst_sreq",  64'(s_req), 64'h0);
    chk("rst_rdata", 64'(m_rdata), 64'h0);
    chk("rst_eaddr", 64'(err_addr), 64'h0);
    chk("rst_saddr", 64'(s_addr), 64'h0);
    m_req = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Lowest index wins on identical windows (second instance)
    txn(32'h0000_0010, 1'b0, 1, 32'h1234_5678, 1'b0, 1'b0);
    chk("ovl_ce", 64'(ovl_ce_acc), 64'h1);
    chk("ovl_rdata", 64'(o_rdata), 64'hAAAA_0000);
    chk("first_lat", 64'(gnt_cycle), 64'd2);

    // Basic read from slave 1
    txn(32'h1000_0004, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rd_lat",   64'(gnt_cycle), 64'd2);
    chk("rd_data",  64'(m_rdata), 64'hDEAD_BEEF);
    chk("rd_ce",    64'(last_ce), 64'b0010);
    chk("rd_err",   64'(last_err), 64'h0);

    // Decode miss
    sreq0 = sreq_cnt;
    txn(32'h5000_0000, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    chk("miss_sreq",  64'(sreq_cnt - sreq0), 64'd0);
    chk("miss_lat",   64'(gnt_cycle), 64'd1);
    chk("miss_err",   64'(last_err), 64'h1);
    chk("miss_eaddr", 64'(err_addr), 64'h5000_0000);
    chk("miss_rdata", 64'(m_rdata), 64'h0);

    // Timeout on slave 2
    ce0 = ce_cnt;
    txn(32'h2000_0000, 1'b0, 99, 32'h0, 1'b0, 1'b0);
    chk("to_ce_cycles", 64'(ce_cnt - ce0), 64'd4);
    chk("to_ce",    64'(last_ce), 64'b0100);
    chk("to_lat",   64'(gnt_cycle), 64'd5);
    chk("to_err",   64'(last_err), 64'h1);
    chk("to_eaddr", 64'(err_addr), 64'h2000_0000);

    // Grant on the last allowed cycle beats the timeout
    txn(32'h3000_0008, 1'b0, TO, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("edge_lat",   64'(gnt_cycle), 64'd5);
    chk("edge_err",   64'(last_err), 64'h0);
    chk("edge_rdata", 64'(m_rdata), 64'hCAFE_F00D);

    // Every other slave grants throughout a slot-0 transaction
    txn(32'h0000_0000, 1'b0, 3, 32'h0BAD_C0DE, 1'b0, 1'b1);
    chk("noise_lat",   64'(gnt_cycle), 64'd4);
    chk("noise_rdata", 64'(m_rdata), 64'h0BAD_C0DE);

    // Write keeps previous read data
    txn(32'h1000_0000, 1'b1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("wr_rdata", 64'(m_rdata), 64'h0BAD_C0DE);

    // Request held through RESP: next transaction waits for one IDLE cycle
    txn(32'h1000_0020, 1'b0, 1, 32'h1111_2222, 1'b1, 1'b0);
    txn(32'h2000_0030, 1'b0, 1, 32'h3333_4444, 1'b0, 1'b0);
    chk("b2b_rdata", 64'(m_rdata), 64'h3333_4444);

    // Asynchronous reset in the middle of an ACTIVE phase
    chk_en = 1'b0;
    m_req = 1'b1; m_addr = 32'h2000_0040; m_we = 1'b0; m_re = 1'b1;
    s_gnt = '0;
    step();
    m_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_sreq", 64'(s_req), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt",   64'(m_gnt), 64'h0);
    chk("arst_err",   64'(m_err), 64'h0);
    chk("arst_ce",    64'(s_ce), 64'h0);
    chk("arst_sreq",  64'(s_req), 64'h0);
    chk("arst_rdata", 64'(m_rdata), 64'h0);
    chk("arst_eaddr", 64'(err_addr), 64'h0);
    chk("arst_saddr", 64'(s_addr), 64'h0);
    chk("arst_swe",   64'(s_we), 64'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    txn(32'h1000_0004, 1'b0, 1, 32'h5555_AAAA, 1'b0, 1'b0);
    chk("post_rst_lat",   64'(gnt_cycle), 64'd2);
    chk("post_rst_rdata", 64'(m_rdata), 64'h5555_AAAA);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [3:0]  nib;
      nib = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                         : 4'($urandom_range(0, 3));
      a = {nib, 28'($urandom)};
      txn(a, 1'($urandom), $urandom_range(1, 6), $urandom,
          bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 4) == 0));
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 Parameter NSLV, default 4, number of slave ports, legal range 1..8.
REQ-002 Parameter DATA_W, default 32, data width; ADDR_W fixed at 32.
REQ-003 Parameter SLV_BASE, default {0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed NSLV*32 base addresses, slot 0 in the low word.
REQ-004 Parameter SLV_MASK, default 0xF000_0000 per slot, packed NSLV*32 compare masks.
REQ-005 Parameter TIMEOUT, default 255, maximum number of ACTIVE cycles waiting for a slave grant, range 1..65535.
REQ-006 i_CLK  in  1  system clock; all state updates on the rising edge.
REQ-007 i_RSTn  in  1  reset, asynchronous and active-low.
REQ-008 i_M_REQ/i_M_WE/i_M_RE  in  1 each  master request, write strobe, read strobe.
REQ-009 i_M_ADDR  in  32, i_M_WDATA  in  DATA_W, i_M_HB  in  2  master address, write data and size code.
REQ-010 o_M_GNT  out  1, o_M_RDATA  out  DATA_W, o_M_ERR  out  1  completion pulse, registered read data, error flag.
REQ-011 o_S_CE  out  NSLV  one-hot slave select; o_S_REQ, o_S_WE  out  1.
REQ-012 o_S_ADDR  out  32, o_S_WDATA  out  DATA_W, o_S_HB  out  2  latched transaction fields.
REQ-013 i_S_GNT  in  NSLV, i_S_RDATA  in  NSLV*DATA_W  per-slave grant and read data.
REQ-014 o_ERR_ADDR  out  32  address of the most recent failed transaction.

Function
REQ-015 The state machine SHALL have three states: IDLE, ACTIVE and RESP.
REQ-016 IDLE with i_M_REQ=1: latch ADDR/WDATA/WE/HB and decode; a hit moves to ACTIVE, a miss moves to RESP with the error flag set.
REQ-017 Slot i hits when (ADDR & MASK_i) == (BASE_i & MASK_i); on multiple hits, the lowest index SHALL win.
REQ-018 ACTIVE SHALL drive o_S_CE one-hot for the latched slot, o_S_REQ=1, and the latched fields.
REQ-019 Outside ACTIVE, o_S_CE SHALL be 0 and o_S_REQ SHALL be 0.
REQ-020 ACTIVE with i_S_GNT[sel]=1: capture slice sel of i_S_RDATA into o_M_RDATA and move to RESP with ERR=0.
REQ-021 Grants from unselected slaves SHALL be ignored.
REQ-022 ACTIVE cycle counter: starts at 1 on entry; at TIMEOUT cycles without grant, move to RESP with ERR=1.
REQ-023 RESP SHALL pulse o_M_GNT=1 for exactly one cycle, with o_M_ERR valid in that same cycle, then return to IDLE.
REQ-024 On error, o_M_RDATA SHALL be 0 and o_ERR_ADDR SHALL update to the latched address.
REQ-025 A write-only transaction (WE=1) SHALL leave o_M_RDATA at its previous value.
REQ-026 Minimum latency, request to o_M_GNT, SHALL be 2 cycles.
REQ-027 Decode-miss latency SHALL be 1 cycle.
REQ-028 Timeout latency SHALL be TIMEOUT+1 cycles.
REQ-029 If i_M_REQ drops during ACTIVE, the transaction SHALL still complete and o_M_GNT SHALL still pulse.
REQ-030 i_M_REQ held high in RESP SHALL NOT start a new transaction until IDLE, so back-to-back transactions are spaced by one IDLE cycle.
REQ-031 When the grant arrives in the same cycle the counter reaches TIMEOUT, the grant SHALL take priority (ERR=0).

Reset
REQ-032 Asserting i_RSTn=0 at any time, including mid-transaction, SHALL force IDLE and clear the counter.
REQ-033 During reset, o_M_GNT, o_M_ERR, o_S_CE and o_S_REQ SHALL be 0.
REQ-034 During reset, o_M_RDATA, o_ERR_ADDR and the latched slave fields SHALL be 0.
REQ-035 The first transaction SHALL be accepted on the first rising edge after i_RSTn returns high.

Structure
REQ-036 A shared package bus_pkg SHALL hold the state enumeration, the HB size codes (byte/half/word) and default base/mask constants.
REQ-037 One sub-module, bus_addr_decode, SHALL implement combinational priority decode of address to one-hot hit and a miss flag.
REQ-038 The timeout counter width SHALL be 16 bits.

Verification
REQ-039 Read 0x1000_0004; slave1 grants in the first ACTIVE cycle with 0xDEAD_BEEF -> o_M_GNT 2 cycles after request, RDATA=0xDEAD_BEEF, ERR=0, o_S_CE=0b0010.
REQ-040 Access 0x5000_0000 -> o_S_REQ never asserted, GNT+ERR at cycle 1, o_ERR_ADDR=0x5000_0000, RDATA=0.
REQ-041 TIMEOUT=4, slave2 never grants -> GNT+ERR at cycle 5, o_S_CE=0b0100 for exactly 4 cycles.
REQ-042 Overlapping windows with BASE1=BASE0 -> access routed to slot 0 only.
REQ-043 Slave3 grant asserted during slot0 transaction -> ignored; slot0 grant later -> slot0 data returned.
REQ-044 Reset asserted in ACTIVE -> all outputs 0 asynchronously; after release, a clean read completes in 2 cycles.
